result_bram_writer: RTL
=======================

// Module: result_bram_writer
// PURPOSE
//  Output-side counterpart of the weight/input BRAM readers in top_system.
//  - Collects per-lane accumulator results (acc_out_0..3 + valid_out) from the systolic core.
//  - Packs each completed row into one 64-bit word.
//  - Writes the word to a BRAM port wired to an AXI BRAM Controller BRAM_PORTA, so the PS reads results back.
//  - Lanes arrive skewed; the block aligns them per row.
// PARAMETERS
//  ACC_W      16    accumulator width per lane; N_MACS*ACC_W must equal DATA_W
//  N_MACS     4     number of lanes
//  DATA_W     64    BRAM data width
//  ADDR_W     11    BRAM byte-address width
//  BASE_ADDR  0     byte address of first result word
//  MAX_ROWS   256   rows written per run before done
// PORTS
//  clk          in   1             system clock
//  rst          in   1             synchronous, active-high reset
//  start        in   1             1-cycle pulse: arm a new run
//  clear_all    in   1             1-cycle pulse: abort run, return to IDLE
//  acc_in_0..3  in   ACC_W each    signed lane results
//  valid_in     in   N_MACS        per-lane result strobe
//  bram_en      out  1             BRAM enable
//  bram_we      out  DATA_W/8      byte write enables
//  bram_addr    out  ADDR_W        byte address
//  bram_din     out  DATA_W        write data
//  bram_dout    in   DATA_W        unused (write-only port); tie-through only
//  busy         out  1             run in progress
//  done         out  1             level; all MAX_ROWS rows written
//  rows_written out  ADDR_W        count of words committed this run
//  overflow     out  1             sticky; lane result dropped
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, lane slots empty, pointer = BASE_ADDR.
//  States and transitions:
//   - IDLE:    start -> COLLECT; pointer=BASE_ADDR, rows_written=0, overflow=0, done=0.
//   - COLLECT: valid_in[i] with slot i empty loads acc_in_i into slot i and marks it full.
//              Every slot full -> WRITE on the next edge.
//   - WRITE:   one cycle; bram_en=1, bram_we=all ones, bram_addr=pointer.
//              bram_din = {slot3,slot2,slot1,slot0}; lane0 in bits [ACC_W-1:0].
//              Next edge: all slots empty, pointer+=DATA_W/8, rows_written+=1.
//              rows_written reaching MAX_ROWS -> DONE, otherwise -> COLLECT.
//   - DONE:    done=1, busy=0; start -> new run as from IDLE.
//  Lane capture in WRITE:
//   - valid_in[i] in the WRITE cycle is accepted into slot i for the next row.
//   - It is not lost; the slot marks full after the flush.
//  Outputs vs state:
//   - busy=1 in COLLECT and WRITE only.
//   - bram_en=0 and bram_we=0 outside WRITE.
//  Latency: last lane valid at cycle t -> BRAM write strobe at cycle t+1.
//  Overflow: valid_in[i] while slot i is full and not in WRITE:
//   - the new value is dropped;
//   - overflow is set to 1 and held until the next start or reset.
//  Ignored inputs:
//   - valid_in in IDLE/DONE is ignored; no overflow is flagged.
//   - start while busy is ignored.
//  clear_all has priority over start and valid_in in any state:
//   - next state IDLE, slots empty, no write issued that cycle;
//   - rows_written and overflow hold their last value.
//  Reset mid-WRITE: the write strobe is deasserted in the cycle after rst is sampled.
//  Pointer wrap: address arithmetic is modulo 2^ADDR_W. MAX_ROWS*8+BASE_ADDR must fit in ADDR_W; a static assertion enforces this.
//  Width check: ACC_W*N_MACS != DATA_W is an elaboration error.
// STRUCTURE
//  Shared package/include:
//   - state encoding localparams (S_IDLE, S_COLLECT, S_WRITE, S_DONE);
//   - DATA_W/8 byte-enable constant;
//   - the shared BRAM port width constants also used by the weight/input readers.
//  Sub-module lane_slot: one per lane; ACC_W data register + full flag.
//   - inputs: load, flush, clr;
//   - outputs: data, full, ovf_pulse.
//  Top of the block holds the FSM, address pointer, row counter and output registers.
// TESTING
//  1. Reset, then start; all 4 lanes valid in one cycle with 1,2,3,4.
//     -> one write at addr 0: din=0x0004_0003_0002_0001, we=0xFF, rows_written=1.
//  2. Skewed lanes: lane0 @t, lane1 @t+1, lane2 @t+2, lane3 @t+3 with -1,-2,-3,-4.
//     -> single write at t+4: din=0xFFFC_FFFD_FFFE_FFFF.
//  3. MAX_ROWS=4; feed 4 rows.
//     -> addrs 0,8,16,24; done=1 and busy=0 after the 4th write; a 5th row is ignored with no write.
//  4. Lane0 valid twice before lane1..3 arrive.
//     -> the second value is dropped, overflow=1, and the written word holds the first value.
//  5. Lane0 valid in the WRITE cycle of row 0.
//     -> the value appears in lane0 of row 1; overflow stays 0.
//  6. clear_all one cycle after 3 lanes are filled.
//     -> no write, state IDLE; a later start resumes at addr BASE_ADDR.
//     rst asserted in the WRITE cycle -> bram_en=0 the next cycle, all outputs 0.

Source files
------------

// File: rtl/result_bram_writer_pkg.sv
// Shared constants and state encoding for the result BRAM writer.
package result_bram_writer_pkg;

  // BRAM port geometry shared with the weight/input readers.
  localparam int unsigned BRAM_DATA_W = 64;
  localparam int unsigned BRAM_ADDR_W = 11;

  // Lane geometry of the systolic core.
  localparam int unsigned LANE_ACC_W = 16;
  localparam int unsigned LANE_COUNT = 4;

  // Number of byte enables for a given data width.
  function automatic int unsigned be_width(input int unsigned data_w);
    return data_w / 8;
  endfunction

  localparam int unsigned BRAM_BE_W = be_width(BRAM_DATA_W);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/result_bram_writer_lane_slot.sv
// One lane's holding slot: a result register plus a full flag.
module result_bram_writer_lane_slot
  import result_bram_writer_pkg::*;
#(
  parameter int unsigned ACC_W = LANE_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             flush,
  input  logic [ACC_W-1:0] din,
  output logic [ACC_W-1:0] data,
  output logic             full,
  output logic             ovf_pulse
);

  logic [ACC_W-1:0] data_q;
  logic             full_q;

  // Capture when empty or being flushed; a flush with no load empties the slot.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (load && (!full_q || flush)) begin
      data_q <= din;
      full_q <= 1'b1;
    end else if (flush) begin
      full_q <= 1'b0;
    end
  end

  // A load into an occupied slot that is not being flushed loses the new value.
  always_comb begin
    ovf_pulse = load && full_q && !flush;
  end

  assign data = data_q;
  assign full = full_q;

endmodule

// File: rtl/result_bram_writer.sv
// Collects skewed per-lane accumulator results, packs each row into one word
// and writes it to a BRAM port readable by the PS.
module result_bram_writer
  import result_bram_writer_pkg::*;
#(
  parameter int unsigned ACC_W     = LANE_ACC_W,
  parameter int unsigned N_MACS    = LANE_COUNT,
  parameter int unsigned DATA_W    = BRAM_DATA_W,
  parameter int unsigned ADDR_W    = BRAM_ADDR_W,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_ROWS  = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    clear_all,
  input  logic signed [ACC_W-1:0] acc_in_0,
  input  logic signed [ACC_W-1:0] acc_in_1,
  input  logic signed [ACC_W-1:0] acc_in_2,
  input  logic signed [ACC_W-1:0] acc_in_3,
  input  logic [N_MACS-1:0]       valid_in,
  output logic                    bram_en,
  output logic [DATA_W/8-1:0]     bram_we,
  output logic [ADDR_W-1:0]       bram_addr,
  output logic [DATA_W-1:0]       bram_din,
  input  logic [DATA_W-1:0]       bram_dout,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       rows_written,
  output logic                    overflow
);

  localparam int unsigned BE_W = be_width(DATA_W);

  if (ACC_W * N_MACS != DATA_W) begin : g_width_err
    $error("ACC_W * N_MACS must equal DATA_W");
  end
  if (N_MACS != 4) begin : g_lane_err
    $error("lane ports are fixed at four");
  end
  if (BASE_ADDR + MAX_ROWS * BE_W > (2 ** ADDR_W)) begin : g_addr_err
    $error("BASE_ADDR + MAX_ROWS * bytes per word exceeds the address space");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] rows_q;
  logic              ovf_q;

  logic [ACC_W-1:0]  lane_in   [N_MACS];
  logic [ACC_W-1:0]  slot_data [N_MACS];
  logic [N_MACS-1:0] slot_full;
  logic [N_MACS-1:0] slot_ovf;
  logic [N_MACS-1:0] lane_load;
  logic [DATA_W-1:0] packed_row;

  logic accept_start, capturing, wr_fire, slot_clr, row_ready, last_row, ovf_set;

  // The read port is write-only here.
  logic unused_dout;
  assign unused_dout = ^bram_dout;

  assign lane_in[0] = acc_in_0;
  assign lane_in[1] = acc_in_1;
  assign lane_in[2] = acc_in_2;
  assign lane_in[3] = acc_in_3;

  for (genvar i = 0; i < N_MACS; i++) begin : g_lane
    result_bram_writer_lane_slot #(
      .ACC_W(ACC_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .clr      (slot_clr),
      .load     (lane_load[i]),
      .flush    (wr_fire),
      .din      (lane_in[i]),
      .data     (slot_data[i]),
      .full     (slot_full[i]),
      .ovf_pulse(slot_ovf[i])
    );
    assign packed_row[i*ACC_W +: ACC_W] = slot_data[i];
  end

  // Qualifiers; clear_all overrides everything else.
  always_comb begin
    accept_start = start && !clear_all && (state_q == S_IDLE || state_q == S_DONE);
    capturing    = !clear_all && (state_q == S_COLLECT || state_q == S_WRITE);
    wr_fire      = !clear_all && (state_q == S_WRITE);
    slot_clr     = clear_all || accept_start;
    lane_load    = valid_in & {N_MACS{capturing}};
    // Lanes landing this cycle count, so the write strobe follows the last lane by one cycle.
    row_ready    = &(slot_full | lane_load);
    last_row     = (rows_q == ADDR_W'(MAX_ROWS - 1));
    ovf_set      = !clear_all && (state_q == S_COLLECT) && (|slot_ovf);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (clear_all) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: if (start) state_d = S_COLLECT;
        S_COLLECT:      if (row_ready) state_d = S_WRITE;
        S_WRITE:        state_d = last_row ? S_DONE : S_COLLECT;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Address pointer, row counter and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= ADDR_W'(BASE_ADDR);
      rows_q <= '0;
      ovf_q  <= 1'b0;
    end else if (accept_start) begin
      ptr_q  <= ADDR_W'(BASE_ADDR);
      rows_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_fire) begin
        ptr_q  <= ptr_q + ADDR_W'(BE_W);
        rows_q <= rows_q + 1'b1;
      end
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // BRAM and status outputs; address and data are zero outside a write.
  always_comb begin
    bram_en      = wr_fire;
    bram_we      = {BE_W{wr_fire}};
    bram_addr    = wr_fire ? ptr_q : '0;
    bram_din     = wr_fire ? packed_row : '0;
    busy         = (state_q == S_COLLECT) || (state_q == S_WRITE);
    done         = (state_q == S_DONE);
    rows_written = rows_q;
    overflow     = ovf_q;
  end

endmodule
